// File: rtl/router_sync.sv
// Steering/synchronizer stage between the router FSM and its three output FIFOs:
// latches the header address, routes write enables, and watches each channel for read stalls.
module router_sync #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int unsigned NCH = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       addr_q, addr_d;
    logic [NCH-1:0]   vld, rd, stall;
    logic [NCH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    assign vld   = {~empty_2, ~empty_1, ~empty_0};
    assign rd    = {read_enb_2, read_enb_1, read_enb_0};
    assign stall = vld & ~rd;

    assign vld_out_0    = vld[0];
    assign vld_out_1    = vld[1];
    assign vld_out_2    = vld[2];
    assign soft_reset_0 = sr_q[0];
    assign soft_reset_1 = sr_q[1];
    assign soft_reset_2 = sr_q[2];

    // Address capture and steering; outputs use the registered address only.
    always_comb begin
        addr_d    = addr_q;
        write_enb = 3'b000;
        fifo_full = 1'b0;
        if (detect_add) begin
            addr_d = data_in;
        end
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // Per-channel stall counters; wrap to zero on the pulse so a continued stall repeats.
    always_comb begin
        sr_d = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
            if (stall[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sr_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= 2'b00;
            sr_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            sr_q   <= sr_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_router_sync.sv
// Self-checking bench for router_sync: directed scenarios plus randomized traffic
// compared against a stall-run-length reference model.
module tb_router_sync;

    localparam int unsigned T = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic [2:0] rd, empty, full;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] vld, sr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: registered address and consecutive-stall run length per channel.
    logic [1:0] m_addr;
    int         m_run [3];
    logic [2:0] m_sr;

    router_sync #(.TIMEOUT(T), .CNT_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0   (rd[0]),
        .read_enb_1   (rd[1]),
        .read_enb_2   (rd[2]),
        .empty_0      (empty[0]),
        .empty_1      (empty[1]),
        .empty_2      (empty[2]),
        .full_0       (full[0]),
        .full_1       (full[1]),
        .full_2       (full[2]),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld[0]),
        .vld_out_1    (vld[1]),
        .vld_out_2    (vld[2]),
        .soft_reset_0 (sr[0]),
        .soft_reset_1 (sr[1]),
        .soft_reset_2 (sr[2])
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] exp_we();
        if (!write_enb_reg || m_addr == 2'd3) return 3'b000;
        return 3'b001 << m_addr;
    endfunction

    function automatic logic exp_full();
        if (m_addr == 2'd3) return 1'b0;
        return full[m_addr];
    endfunction

    // Advance one clock; model consumes the inputs present at the edge, then outputs settle.
    task automatic tick();
        logic [2:0] st;
        logic       rs, da;
        logic [1:0] di;
        st = ~empty & ~rd;
        rs = reset;
        da = detect_add;
        di = data_in;
        @(posedge clock);
        cyc++;
        if (rs) begin
            m_addr = 2'b00;
            m_sr   = 3'b000;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            if (da) m_addr = di;
            for (int i = 0; i < 3; i++) begin
                if (st[i]) begin
                    m_run[i]++;
                    m_sr[i] = (m_run[i] % T == 0);
                end else begin
                    m_run[i] = 0;
                    m_sr[i]  = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b0;
        rd = 3'b000; empty = 3'b111; full = 3'b010;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (write_enb !== 3'b000) begin bad++; $display("FAIL reset_we got=%b exp=000", write_enb); end
        total++;
        if (fifo_full !== full[0]) begin bad++; $display("FAIL reset_full got=%b exp=%b", fifo_full, full[0]); end
        total++;
        if (vld !== 3'b000) begin bad++; $display("FAIL reset_vld got=%b exp=000", vld); end
        for (int k = 0; k < 40; k++) begin
            tick();
            total++;
            if (sr !== 3'b000) begin bad++; $display("FAIL idle_sr cyc=%0d got=%b exp=000", cyc, sr); end
        end
    endtask

    task automatic test_addr_steer();
        detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; full = 3'b100;
        #1;
        // Capture and write together: steering still uses the old address.
        total++;
        if (write_enb !== 3'b001) begin bad++; $display("FAIL same_cycle_we got=%b exp=001", write_enb); end
        tick();
        detect_add = 1'b0;
        #1;
        total++;
        if (write_enb !== 3'b100) begin bad++; $display("FAIL steer_we got=%b exp=100", write_enb); end
        total++;
        if (fifo_full !== 1'b1) begin bad++; $display("FAIL steer_full got=%b exp=1", fifo_full); end
        full[1] = 1'b1;
        #1;
        total++;
        if (fifo_full !== 1'b1) begin bad++; $display("FAIL steer_full_t1 got=%b exp=1", fifo_full); end
        full[2] = 1'b0;
        #1;
        total++;
        if (fifo_full !== 1'b0) begin bad++; $display("FAIL steer_full_f2 got=%b exp=0", fifo_full); end
    endtask

    task automatic test_invalid_addr();
        detect_add = 1'b1; data_in = 2'b11; write_enb_reg = 1'b1; full = 3'b111;
        tick();
        detect_add = 1'b0;
        #1;
        total++;
        if (write_enb !== 3'b000) begin bad++; $display("FAIL inval_we got=%b exp=000", write_enb); end
        total++;
        if (fifo_full !== 1'b0) begin bad++; $display("FAIL inval_full got=%b exp=0", fifo_full); end
        write_enb_reg = 1'b0;
    endtask

    task automatic test_timeout_ch1();
        int pulses;
        int at [$];
        pulses = 0;
        empty = 3'b101; rd = 3'b000;
        #1;
        total++;
        if (vld !== 3'b010) begin bad++; $display("FAIL vld_ch1 got=%b exp=010", vld); end
        for (int k = 1; k <= 65; k++) begin
            tick();
            total++;
            if (sr !== m_sr) begin bad++; $display("FAIL to1_sr edge=%0d got=%b exp=%b", k, sr, m_sr); end
            if (sr[1]) begin pulses++; at.push_back(k); end
        end
        total++;
        if (pulses != 2 || at[0] != 30 || at[1] != 60) begin
            bad++; $display("FAIL to1_pulses got=%0d exp=2 (edges 30,60)", pulses);
        end
        empty = 3'b111;
        tick();
    endtask

    task automatic test_read_restart();
        empty = 3'b110; rd = 3'b000;
        for (int k = 1; k <= 62; k++) begin
            rd[0] = (k == 30);
            tick();
            total++;
            if (sr[0] !== ((k == 60) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL restart_sr0 edge=%0d got=%b exp=%b", k, sr[0], (k == 60));
            end
            total++;
            if (sr !== m_sr) begin bad++; $display("FAIL restart_model edge=%0d got=%b exp=%b", k, sr, m_sr); end
        end
        rd = 3'b000; empty = 3'b111;
        tick();
    endtask

    task automatic test_reset_midcount();
        empty = 3'b011; rd = 3'b000; write_enb_reg = 1'b1; full = 3'b000;
        detect_add = 1'b1; data_in = 2'b01;
        tick();
        detect_add = 1'b0;
        for (int k = 0; k < 19; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (write_enb !== 3'b001) begin bad++; $display("FAIL rst_addr_we got=%b exp=001", write_enb); end
        for (int k = 1; k <= 31; k++) begin
            tick();
            total++;
            if (sr[2] !== ((k == 30) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL rst_mid_sr2 edge=%0d got=%b exp=%b", k, sr[2], (k == 30));
            end
        end
        empty = 3'b111; write_enb_reg = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int k = 0; k < 2000; k++) begin
            reset         = ($urandom_range(0, 199) == 0);
            detect_add    = ($urandom_range(0, 9) == 0);
            data_in       = 2'($urandom_range(0, 3));
            write_enb_reg = 1'($urandom);
            full          = 3'($urandom);
            for (int i = 0; i < 3; i++) begin
                empty[i] = ($urandom_range(0, 15) == 0);
                rd[i]    = ($urandom_range(0, 49) == 0);
            end
            #1;
            total++;
            if (write_enb !== exp_we()) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, write_enb, exp_we()); end
            total++;
            if (fifo_full !== exp_full()) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, fifo_full, exp_full()); end
            total++;
            if (vld !== ~empty) begin bad++; $display("FAIL rnd_vld cyc=%0d got=%b exp=%b", cyc, vld, ~empty); end
            tick();
            total++;
            if (sr !== m_sr) begin bad++; $display("FAIL rnd_sr cyc=%0d got=%b exp=%b", cyc, sr, m_sr); end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_addr = 2'b00;
        m_sr   = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        test_reset();
        test_addr_steer();
        test_invalid_addr();
        test_timeout_ch1();
        test_read_restart();
        test_reset_midcount();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_sync.md
Name: router_sync

Overview:
- Synchronizer/steering stage between the router control FSM and the three output FIFOs of the 1x3 router.
- Latches the destination address when the FSM is in its address-decode state.
- Steers the FSM's single write-enable to the selected FIFO and returns that FIFO's full flag to the FSM.
- Per output channel: drives vld_out from FIFO non-empty and runs a read-timeout counter that pulses soft_reset when the destination stops reading.

Parameters:
- TIMEOUT, 30, consecutive stalled cycles (vld_out high, read_enb low) before soft_reset pulses; legal range 2..2**CNT_W.
- CNT_W, 5, width of each timeout counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  FSM is in address-decode state; capture data_in.
- data_in  in  2  packet header address bits (00/01/10 valid; 11 invalid).
- write_enb_reg  in  1  FSM write request for the currently addressed FIFO.
- read_enb_0/1/2  in  1 each  destination read strobe per channel.
- empty_0/1/2  in  1 each  FIFO empty flags.
- full_0/1/2  in  1 each  FIFO full flags.
- write_enb  out  3  one-hot FIFO write enable; bit n drives FIFO n.
- fifo_full  out  1  full flag of the addressed FIFO, to FSM.
- vld_out_0/1/2  out  1 each  channel has data (= ~empty_n).
- soft_reset_0/1/2  out  1 each  one-cycle timeout pulse, to FSM and FIFO n.

Behaviour:
- Reset (reset=1 at an edge):
  - addr_reg <= 2'b00.
  - All timeout counters <= 0.
  - soft_reset_0/1/2 <= 0.
  - Combinational outputs follow from the reset register values: write_enb=000 unless write_enb_reg=1; fifo_full=full_0; vld_out_n=~empty_n.
  - Reset has priority over every other event; reset mid-count discards the count.
- Address capture:
  - If detect_add=1 at an edge, addr_reg <= data_in. Otherwise addr_reg holds.
  - One-cycle latency: the new address steers outputs from the following cycle.
  - data_in=11 is captured as-is (no error flag).
- write_enb, combinational:
  - write_enb_reg=0 -> 000.
  - write_enb_reg=1 -> addr 00:001, 01:010, 10:100, 11:000.
- fifo_full, combinational: addr 00:full_0, 01:full_1, 10:full_2, 11:0.
- vld_out_n = ~empty_n, combinational, independent of addr_reg.
- Timeout counter, per channel n, independent across channels, evaluated each edge:
  - If vld_out_n=1 and read_enb_n=0 (stall):
    - if cnt_n==TIMEOUT-1: soft_reset_n<=1 and cnt_n<=0;
    - else: cnt_n<=cnt_n+1 and soft_reset_n<=0.
  - Otherwise: cnt_n<=0 and soft_reset_n<=0.
  - Net effect: soft_reset_n is high for exactly one cycle, starting the cycle after the TIMEOUT-th consecutive stall cycle.
  - A continued stall produces the next pulse TIMEOUT cycles later.
  - A single read_enb_n=1 cycle, or the FIFO going empty, restarts the count from 0.
  - read_enb_n=1 while empty_n=1 has no effect beyond clearing cnt_n.
- Simultaneous events:
  - detect_add together with write_enb_reg: write_enb uses the old addr_reg in that cycle.
  - Soft-reset pulses on several channels in the same cycle are allowed.
  - soft_reset_n does not clear addr_reg.
- No internal state beyond addr_reg, 3 counters and 3 soft_reset flops.

Test Plan:
- Reset, then empty_*=1 and write_enb_reg=0 -> write_enb=000, fifo_full=full_0, vld_out_*=0, soft_reset_*=0; hold 40 cycles -> no pulses.
- detect_add=1 with data_in=10 at edge k, then write_enb_reg=1 and full_2=1 -> from cycle k+1: write_enb=100, fifo_full=1; toggle full_1 -> fifo_full unchanged.
- data_in=11 captured, write_enb_reg=1 -> write_enb=000, fifo_full=0 with all full_*=1.
- empty_1=0, read_enb_1=0 for 30 cycles from edge 1 -> soft_reset_1=1 only in cycle after edge 30; keep stalling -> next pulse after edge 60; soft_reset_0/2 stay 0.
- empty_0=0, stall 29 cycles, read_enb_0=1 for 1 cycle, stall again -> no pulse until 30 further stall cycles.
- Stall channel 2 for 20 cycles, then assert reset for 1 cycle, then continue stalling -> pulse only after 30 stall cycles counted after reset; addr_reg=00.
